// File: rtl/mem_ctrl_pkg.sv
// Shared types and encodings for the data-memory stall controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } ctrlState_t;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // The reserved MemOp code 11 behaves as a word access.
  function automatic logic [1:0] normSize(input logic [1:0] memOp);
    return (memOp == 2'b11) ? SIZE_WORD : memOp;
  endfunction

  // Words need 4-byte alignment, halves 2-byte; bytes always fit.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLow);
    logic result;
    result = 1'b0;
    if (size == SIZE_WORD && addrLow != 2'b00) result = 1'b1;
    if (size == SIZE_HALF && addrLow[0])       result = 1'b1;
    return result;
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts BUSY cycles spent waiting for a memory acknowledge.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // Restart on a new access, otherwise advance while waiting, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && count != LAST) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_stall_ctrl.sv
// Stalls the pipeline while a load/store waits on the data memory.
module mem_stall_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [1:0]  MEM_MemOp,
  input  logic [31:0] MEM_aluResult,
  input  logic [31:0] MEM_rfOut2,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        mem_bubble,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        err,
  output logic [1:0]  err_code
);

  ctrlState_t state, nextState;

  logic        access;
  logic [1:0]  reqSize;
  logic        misaligned;
  logic        startAccess;
  logic        expired;
  logic        timedOut;

  logic        latWe;
  logic [1:0]  latSize;
  logic [31:0] latAddr;
  logic [31:0] latWdata;
  logic [1:0]  errCodeReg;
  logic [31:0] rdataReg;

  assign access      = MEM_MemRead | MEM_MemWrite;
  assign reqSize     = normSize(MEM_MemOp);
  assign misaligned  = isMisaligned(reqSize, MEM_aluResult[1:0]);
  assign startAccess = (state == IDLE) && access && !misaligned;
  assign timedOut    = (state == BUSY) && !mem_ack && expired;

  mem_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) timeoutCnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (startAccess),
    .enable ((state == BUSY) && !mem_ack),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic; an acknowledge always beats a timeout in the same cycle.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (access && misaligned) nextState = ERR;
        else if (access)          nextState = BUSY;
      end
      BUSY: begin
        if (mem_ack)      nextState = DONE;
        else if (expired) nextState = ERR;
      end
      DONE:    nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Capture the request at issue, the error cause, and returned load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latWe      <= 1'b0;
      latSize    <= SIZE_WORD;
      latAddr    <= 32'd0;
      latWdata   <= 32'd0;
      errCodeReg <= ERR_NONE;
      rdataReg   <= 32'd0;
    end else begin
      if (startAccess) begin
        latWe    <= MEM_MemWrite;
        latSize  <= reqSize;
        latAddr  <= MEM_aluResult;
        latWdata <= MEM_rfOut2;
      end
      if ((state == IDLE) && access && misaligned) errCodeReg <= ERR_MISALIGN;
      else if (timedOut)                           errCodeReg <= ERR_TIMEOUT;
      if ((state == BUSY) && mem_ack && !latWe) rdataReg <= mem_rdata;
    end
  end

  // Per-state outputs toward the memory and the pipeline.
  always_comb begin
    mem_req     = 1'b0;
    stall       = 1'b0;
    mem_bubble  = 1'b0;
    rdata_valid = 1'b0;
    err         = 1'b0;
    err_code    = ERR_NONE;
    case (state)
      IDLE: stall = access && !misaligned;
      BUSY: begin
        mem_req = 1'b1;
        stall   = 1'b1;
      end
      DONE: rdata_valid = !latWe;
      ERR: begin
        err        = 1'b1;
        err_code   = errCodeReg;
        mem_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_we    = latWe;
  assign mem_size  = latSize;
  assign mem_addr  = latAddr;
  assign mem_wdata = latWdata;
  assign rdata_out = rdataReg;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Randomised scoreboard bench for mem_stall_ctrl.
module tb_mem_stall_ctrl;

  localparam int TO = 4;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        isErr;
    logic [1:0]  code;
    logic [31:0] data;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [1:0]  MEM_MemOp;
  logic [31:0] MEM_aluResult;
  logic [31:0] MEM_rfOut2;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        mem_bubble;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  req_t  reqQ[$];
  resp_t respQ[$];
  logic [31:0] lastRead = 32'd0;
  logic        prevReq  = 1'b0;

  mem_stall_ctrl #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MEM_MemRead  (MEM_MemRead),
    .MEM_MemWrite (MEM_MemWrite),
    .MEM_MemOp    (MEM_MemOp),
    .MEM_aluResult(MEM_aluResult),
    .MEM_rfOut2   (MEM_rfOut2),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_size     (mem_size),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .stall        (stall),
    .mem_bubble   (mem_bubble),
    .rdata_out    (rdata_out),
    .rdata_valid  (rdata_valid),
    .err          (err),
    .err_code     (err_code)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    MEM_MemRead   = 1'b0;
    MEM_MemWrite  = 1'b0;
    MEM_MemOp     = 2'b00;
    MEM_aluResult = 32'd0;
    MEM_rfOut2    = 32'd0;
    mem_ack       = 1'b0;
    mem_rdata     = 32'd0;
  endtask

  // Issues one memory instruction, plays the memory side, and predicts the outcome.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] op,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int ackDelay, input logic [31:0] rdata);
    logic [1:0] size;
    logic       mis;
    logic       willAck;
    int         expReq, expStall, busy, reqCnt, stallCnt;
    bit         done;
    req_t       rq;
    resp_t      rs;

    size    = (op == 2'b11) ? 2'b00 : op;
    mis     = (size == 2'b00 && addr[1:0] != 2'b00) || (size == 2'b01 && addr[0]);
    willAck = ackDelay < TO;

    if (mis) begin
      rs = '{isErr: 1'b1, code: 2'b01, data: 32'd0};
      respQ.push_back(rs);
      expReq = 0;
    end else begin
      rq = '{we: wr, size: size, addr: addr, wdata: wdata};
      reqQ.push_back(rq);
      if (!willAck) begin
        rs = '{isErr: 1'b1, code: 2'b10, data: 32'd0};
        respQ.push_back(rs);
        expReq = TO;
      end else begin
        if (!wr) begin
          rs = '{isErr: 1'b0, code: 2'b00, data: rdata};
          respQ.push_back(rs);
          lastRead = rdata;
        end
        expReq = ackDelay + 1;
      end
    end
    expStall = mis ? 0 : expReq + 1;

    @(negedge clk);
    MEM_MemRead   = rd;
    MEM_MemWrite  = wr;
    MEM_MemOp     = op;
    MEM_aluResult = addr;
    MEM_rfOut2    = wdata;
    mem_ack       = 1'b0;
    #1;

    busy = 0; reqCnt = 0; stallCnt = 0; done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        #1;
      end
      if (mem_req) begin
        mem_ack   = (busy == ackDelay);
        mem_rdata = mem_ack ? rdata : $urandom;
        reqCnt++;
        busy++;
      end else begin
        mem_ack = 1'b0;
      end
      if (stall) stallCnt++;
      else       done = 1;
    end
    checkOutput("drvFinished", 32'(done), 32'd1);
    checkOutput("reqCycles", reqCnt, expReq);
    checkOutput("stallCycles", stallCnt, expStall);

    @(posedge clk);
    #1;
    clearInputs();
    if (mis) begin
      @(posedge clk);
      #1;
    end
    if (!mis && !willAck) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hBADBAD00;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      checkOutput("lateAckNoReq", 32'(mem_req), 32'd0);
    end
    checkOutput("rdataHold", rdata_out, lastRead);
  endtask

  // Monitor: pops an expectation whenever the DUT issues a request or a response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req && !prevReq) begin
        if (reqQ.size() == 0) begin
          checkOutput("unexpectedReq", 32'd1, 32'd0);
        end else begin
          req_t e;
          e = reqQ.pop_front();
          checkOutput("reqWe", 32'(mem_we), 32'(e.we));
          checkOutput("reqSize", 32'(mem_size), 32'(e.size));
          checkOutput("reqAddr", mem_addr, e.addr);
          checkOutput("reqWdata", mem_wdata, e.wdata);
        end
      end
      if (rdata_valid || err) begin
        if (respQ.size() == 0) begin
          checkOutput("unexpectedResp", 32'd1, 32'd0);
        end else begin
          resp_t e;
          e = respQ.pop_front();
          checkOutput("respErr", 32'(err), 32'(e.isErr));
          checkOutput("respValid", 32'(rdata_valid), 32'(!e.isErr));
          checkOutput("respCode", 32'(err_code), 32'(e.code));
          checkOutput("respBubble", 32'(mem_bubble), 32'(e.isErr));
          checkOutput("respStall", 32'(stall), 32'd0);
          if (!e.isErr) checkOutput("respData", rdata_out, e.data);
        end
      end
    end
    prevReq = mem_req;
  end

  initial begin
    int guard;
    logic rd, wr;
    logic [31:0] addr;

    clearInputs();
    rst_n = 1'b0;
    #2;
    checkOutput("rstReq", 32'(mem_req), 32'd0);
    checkOutput("rstStall", 32'(stall), 32'd0);
    checkOutput("rstErr", {29'd0, err, err_code}, 32'd0);
    checkOutput("rstValid", 32'(rdata_valid), 32'd0);
    checkOutput("rstRdata", rdata_out, 32'd0);
    checkOutput("rstAddr", mem_addr, 32'd0);
    #20;
    rst_n = 1'b1;

    $display("[TB] load word with ack in third BUSY cycle");
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    $display("[TB] misaligned half store");
    applyStimulus(1'b0, 1'b1, 2'b01, 32'h103, 32'h1234, 0, 32'h0);
    $display("[TB] timeout with late ack");
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h200, 32'h0, 10, 32'h55AA55AA);
    $display("[TB] read+write byte treated as write");
    applyStimulus(1'b1, 1'b1, 2'b10, 32'h001, 32'hCAFEF00D, 1, 32'h0);
    $display("[TB] back-to-back loads");
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h300, 32'h0, 0, 32'h11111111);
    applyStimulus(1'b1, 1'b0, 2'b11, 32'h304, 32'h0, 0, 32'h22222222);

    $display("[TB] reset mid-BUSY");
    @(negedge clk);
    MEM_MemRead   = 1'b1;
    MEM_aluResult = 32'h400;
    reqQ.push_back('{we: 1'b0, size: 2'b00, addr: 32'h400, wdata: 32'h0});
    guard = 0;
    while (!mem_req && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("resetTestReqSeen", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    clearInputs();
    #1;
    checkOutput("midRstReq", 32'(mem_req), 32'd0);
    checkOutput("midRstStall", 32'(stall), 32'd0);
    checkOutput("midRstRdata", rdata_out, 32'd0);
    checkOutput("midRstAddr", mem_addr, 32'd0);
    lastRead = 32'd0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hFEEDFACE;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    checkOutput("postRstNoReq", 32'(mem_req), 32'd0);
    checkOutput("postRstRdata", rdata_out, 32'd0);

    $display("[TB] randomised traffic");
    for (int i = 0; i < 60; i++) begin
      rd = $urandom_range(0, 1);
      wr = $urandom_range(0, 1);
      if (!rd && !wr) rd = 1'b1;
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
      applyStimulus(rd, wr, 2'($urandom_range(0, 3)), addr, $urandom,
                    $urandom_range(0, 5), $urandom);
    end

    repeat (4) @(negedge clk);
    checkOutput("reqQEmpty", reqQ.size(), 32'd0);
    checkOutput("respQEmpty", respQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL give the maximum BUSY cycles waited for mem_ack before an error (legal range 2..255).
REQ-002 Port clk  in  1: sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  in  1: reset; asynchronous, active-low.
REQ-004 Ports MEM_MemRead, MEM_MemWrite  in  1 each: memory-access request of the instruction held in the EX/MEM register.
REQ-005 Port MEM_MemOp  in  2: access size; 00 word, 01 half, 10 byte, 11 SHALL be treated as word.
REQ-006 Ports MEM_aluResult, MEM_rfOut2  in  32 each: access address and store data.
REQ-007 Ports mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  32; mem_size  out  2: data-memory request bus.
REQ-008 Ports mem_ack  in  1; mem_rdata  in  32: memory completion strobe and load data.
REQ-009 Port stall  out  1: holds PC, IF/ID, ID/EX and EX/MEM registers.
REQ-010 Port mem_bubble  out  1: forces a no-write bubble into MEM/WB.
REQ-011 Ports rdata_out  out  32; rdata_valid  out  1: captured load data and its one-cycle valid.
REQ-012 Ports err  out  1; err_code  out  2: one-cycle error pulse; 01 misaligned, 10 timeout.

Function
REQ-013 access SHALL equal MEM_MemRead OR MEM_MemWrite; if both are 1, the access SHALL be a write.
REQ-014 misaligned SHALL be 1 for word with addr[1:0]!=0 or half with addr[0]!=0; byte is never misaligned.
REQ-015 FSM states IDLE, BUSY, DONE, ERR SHALL be implemented.
REQ-016 IDLE: access & !misaligned -> BUSY, latching addr, wdata, size and we; access & misaligned -> ERR; else remain in IDLE.
REQ-017 BUSY: mem_req=1 with the latched fields; mem_ack -> DONE, capturing mem_rdata into rdata_out if the access is a read.
REQ-018 BUSY: the timeout counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ack; at count TIMEOUT-1 without mem_ack -> ERR with err_code 10.
REQ-019 mem_ack and timeout in the same cycle: mem_ack SHALL win.
REQ-020 DONE: stall=0, rdata_valid=1 for reads only, then unconditionally -> IDLE.
REQ-021 ERR: err=1, stall=0, mem_bubble=1 for one cycle, then -> IDLE.
REQ-022 stall SHALL equal (IDLE & access & !misaligned) OR BUSY; it is combinational from state and inputs.
REQ-023 mem_req SHALL be 0 outside BUSY; mem_ack outside BUSY SHALL be ignored, including a late ack after timeout.
REQ-024 Minimum latency: access seen in cycle 0, ack in cycle 1, DONE in cycle 2; stall is high in cycles 0-1.
REQ-025 Back-to-back accesses SHALL each pass through IDLE; no access overlaps another.
REQ-026 rdata_out SHALL hold its value until the next captured read.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, counter 0, mem_req 0, rdata_valid 0, err 0, err_code 00, rdata_out 0, and latched fields 0, independent of clk.
REQ-028 A reset during BUSY SHALL abandon the access; a subsequent mem_ack SHALL be ignored.

Structure
REQ-029 Package mem_ctrl_pkg SHALL hold the FSM state type, the MemOp size encodings and the err_code values.
REQ-030 Sub-module mem_timeout_cnt (clear, enable, expired at TIMEOUT-1) SHALL be instantiated once.

Verification
REQ-031 Test 1: load word to 0x100, ack after 3 BUSY cycles, rdata 0xDEADBEEF -> stall high for 4 cycles, then rdata_valid=1 and rdata_out=0xDEADBEEF.
REQ-032 Test 2: store half to 0x103 -> no mem_req, err=1, err_code=01, mem_bubble=1 for one cycle, stall never high.
REQ-033 Test 3: TIMEOUT=4, no ack -> mem_req high for 4 cycles, then err_code=10; a late ack changes nothing.
REQ-034 Test 4: rst_n low mid-BUSY -> mem_req drops 0 without a clk edge; state returns to IDLE.
REQ-035 Test 5: MemRead and MemWrite both 1 with byte size at 0x001 -> mem_we=1, mem_size=10, and no error.
REQ-036 Test 6: two consecutive loads with ack in the first BUSY cycle -> the DONE cycle separates the two requests, and both values are captured in order.
